// File: rtl/lift_share_sequencer.sv
// lift_share_sequencer: buffers residue shares and quo*q mod p_i products in
// two FIFOs and issues them in GROUP-word modulus groups. Each share goes out
// with a_shares_we, and its product follows on quo_x_q_mod_pi LAT cycles later.
// Optional build macro LIFT_SEQ_STATS_EN adds the group_count and skew_err ports.
module lift_share_sequencer #(
  parameter int DEPTH = 16,
  parameter int GROUP = 7,
  parameter int LAT   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic [29:0] share_in,
  input  logic        share_in_valid,
  output logic        share_in_ready,
  input  logic [29:0] prod_in,
  input  logic        prod_in_valid,
  output logic        prod_in_ready,
  output logic [29:0] a_shares,
  output logic        a_shares_we,
  output logic [29:0] quo_x_q_mod_pi,
  output logic        mode_out,
  output logic        busy
`ifdef LIFT_SEQ_STATS_EN
  ,
  output logic [15:0] group_count,
  output logic        skew_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (GROUP > 1) ? $clog2(GROUP) : 1;
  localparam logic [CW-1:0] C_GROUP = CW'(GROUP);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic          w_grp_start, w_grp_last;

  logic [29:0]   r_sh_mem [DEPTH];
  logic [AW-1:0] r_sh_wp, r_sh_rp;
  logic [CW-1:0] r_sh_cnt, w_sh_cnt_nxt;
  logic          r_sh_rdy, w_sh_push, w_sh_pop;

  logic [29:0]   r_pr_mem [DEPTH];
  logic [AW-1:0] r_pr_wp, r_pr_rp;
  logic [CW-1:0] r_pr_cnt, w_pr_cnt_nxt;
  logic          r_pr_rdy, w_pr_push, w_pr_pop;

  logic [LAT-1:0] r_stb, w_stb_nxt;
  logic [CW-1:0]  w_pend, w_pr_free;

  logic [29:0] r_a_shares, r_quo;
  logic        r_we, r_mode, r_busy;

  assign w_sh_push    = share_in_valid & r_sh_rdy;
  assign w_sh_pop     = (r_state == S_ISSUE);
  assign w_sh_cnt_nxt = r_sh_cnt + CW'(w_sh_push) - CW'(w_sh_pop);

  // Product pops are driven purely by the aligned share-pop strobe.
  assign w_pr_push    = prod_in_valid & r_pr_rdy;
  assign w_pr_pop     = r_stb[LAT-1];
  assign w_pr_cnt_nxt = r_pr_cnt + CW'(w_pr_push) - CW'(w_pr_pop);
  assign w_stb_nxt    = (r_stb << 1) | LAT'(w_sh_pop);

  // Products already claimed by in-flight strobes are not free for a new group.
  always_comb begin
    w_pend = '0;
    for (int i = 0; i < LAT; i++) w_pend = w_pend + CW'(r_stb[i]);
  end
  assign w_pr_free = r_pr_cnt - w_pend;

  // Next-state logic: open a group when both FIFOs can cover it in full.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_grp_start = 1'b0;
    w_grp_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_sh_cnt >= C_GROUP && w_pr_free >= C_GROUP) begin
          w_state_nxt = S_ISSUE;
          w_idx_nxt   = '0;
          w_grp_start = 1'b1;
        end
      end
      S_ISSUE: begin
        if (r_idx == IW'(GROUP - 1)) begin
          w_grp_last = 1'b1;
          w_idx_nxt  = '0;
          // This cycle pops one share and claims one product.
          if ((r_sh_cnt - C_ONE) >= C_GROUP && (w_pr_free - C_ONE) >= C_GROUP) begin
            w_grp_start = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_idx_nxt = r_idx + IW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Share FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_wp  <= '0;
      r_sh_rp  <= '0;
      r_sh_cnt <= '0;
      r_sh_rdy <= 1'b1;
    end else begin
      if (w_sh_push) r_sh_wp <= r_sh_wp + AW'(1);
      if (w_sh_pop)  r_sh_rp <= r_sh_rp + AW'(1);
      r_sh_cnt <= w_sh_cnt_nxt;
      r_sh_rdy <= (w_sh_cnt_nxt < C_DEPTH);
    end
  end

  // Product FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pr_wp  <= '0;
      r_pr_rp  <= '0;
      r_pr_cnt <= '0;
      r_pr_rdy <= 1'b1;
    end else begin
      if (w_pr_push) r_pr_wp <= r_pr_wp + AW'(1);
      if (w_pr_pop)  r_pr_rp <= r_pr_rp + AW'(1);
      r_pr_cnt <= w_pr_cnt_nxt;
      r_pr_rdy <= (w_pr_cnt_nxt < C_DEPTH);
    end
  end

  // FIFO storage; emptiness is owned by the pointers, so no reset here.
  always_ff @(posedge clk) begin
    if (w_sh_push) r_sh_mem[r_sh_wp] <= share_in;
    if (w_pr_push) r_pr_mem[r_pr_wp] <= prod_in;
  end

  // Output registers and the product-alignment strobe line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_shares <= '0;
      r_we       <= 1'b0;
      r_quo      <= '0;
      r_mode     <= 1'b0;
      r_busy     <= 1'b0;
      r_stb      <= '0;
    end else begin
      r_we  <= w_sh_pop;
      r_stb <= w_stb_nxt;
      if (w_sh_pop)    r_a_shares <= r_sh_mem[r_sh_rp];
      if (w_pr_pop)    r_quo      <= r_pr_mem[r_pr_rp];
      if (w_grp_start) r_mode     <= mode;
      r_busy <= (w_state_nxt == S_ISSUE) | (|w_stb_nxt);
    end
  end

`ifdef LIFT_SEQ_STATS_EN
  logic [15:0] r_gcnt;
  logic        r_skew;

  // Completed-group counter and sticky push-while-full flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gcnt <= '0;
      r_skew <= 1'b0;
    end else begin
      if (w_grp_last) r_gcnt <= r_gcnt + 16'd1;
      if ((share_in_valid & ~r_sh_rdy) | (prod_in_valid & ~r_pr_rdy)) r_skew <= 1'b1;
    end
  end

  assign group_count = r_gcnt;
  assign skew_err    = r_skew;
`endif

  assign share_in_ready = r_sh_rdy;
  assign prod_in_ready  = r_pr_rdy;
  assign a_shares       = r_a_shares;
  assign a_shares_we    = r_we;
  assign quo_x_q_mod_pi = r_quo;
  assign mode_out       = r_mode;
  assign busy           = r_busy;

endmodule
